// File: rtl/iter_alu.sv
// Multi-cycle EXE ALU: single-cycle logic/arith ops plus iterative MUL/UDIV/UREM.
// Latency 1 cycle for single-cycle ops, N+1 for MUL/UDIV/UREM; define ITER_ALU_EARLY_EXIT_EN to let MUL finish early.
// Backpressure: the result is held in DONE until out_ready; in_ready is low while busy or while a result is unconsumed.
module iter_alu #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   EXE_CMD,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carryIn,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic [3:0]   status
);

  localparam logic [3:0] OP_MOV   = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_ADC   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_SBC   = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_ORR   = 4'b0111;
  localparam logic [3:0] OP_EOR   = 4'b1000;
  localparam logic [3:0] OP_MVN   = 4'b1001;
  localparam logic [3:0] OP_SORT1 = 4'b1010;
  localparam logic [3:0] OP_SORT2 = 4'b1011;
  localparam logic [3:0] OP_MUL   = 4'b1100;
  localparam logic [3:0] OP_UDIV  = 4'b1101;
  localparam logic [3:0] OP_UREM  = 4'b1110;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [N-1:0]     b_q;
  logic [2*N-1:0]   mcand_q, acc_q;
  logic [N-1:0]     mb_q, quo_q;
  logic [N:0]       rem_q;
  logic [CW-1:0]    cnt_q;
  logic [N-1:0]     out_q;
  logic [3:0]       status_q;

  logic accept, is_iter;
  assign is_iter   = (EXE_CMD == OP_MUL) | (EXE_CMD == OP_UDIV) | (EXE_CMD == OP_UREM);
  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign status    = status_q;

  // SORT2 reuses the subtractor with swapped operands so both sorts read one sign bit.
  logic [N-1:0] sub_x, sub_y;
  logic [N:0]   add_r, sub_r;
  assign sub_x = (EXE_CMD == OP_SORT2) ? b : a;
  assign sub_y = (EXE_CMD == OP_SORT2) ? a : b;
  assign add_r = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, (EXE_CMD == OP_ADC) & carryIn};
  assign sub_r = {1'b0, sub_x} - {1'b0, sub_y} - {{N{1'b0}}, (EXE_CMD == OP_SBC) & ~carryIn};

  logic [N-1:0] sc_out;
  logic         sc_c, sc_v;
  logic [3:0]   sc_status;

  always_comb begin
    sc_out = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (EXE_CMD)
      OP_MOV: sc_out = b;
      OP_MVN: sc_out = ~b;
      OP_ADD, OP_ADC: begin
        sc_out = add_r[N-1:0];
        sc_c   = add_r[N];
        sc_v   = (a[N-1] == b[N-1]) & (add_r[N-1] != a[N-1]);
      end
      OP_SUB, OP_SBC: begin
        sc_out = sub_r[N-1:0];
        sc_c   = sub_r[N];
        sc_v   = (a[N-1] != b[N-1]) & (sub_r[N-1] != a[N-1]);
      end
      OP_AND: sc_out = a & b;
      OP_ORR: sc_out = a | b;
      OP_EOR: sc_out = a ^ b;
      OP_SORT1, OP_SORT2: sc_out = sub_r[N-1] ? b : a;
      default: sc_out = '0;
    endcase
  end
  assign sc_status = {sc_out[N-1], ~|sc_out, sc_c, sc_v};

  // One iteration step: shift-add multiply and restoring divide share the EXEC counter.
  logic [2*N-1:0] acc_nx;
  logic [N-1:0]   mb_nx, quo_nx;
  logic [N+1:0]   prem, trial;
  logic [N:0]     rem_nx;
  logic           div_ge, mul_early, step_last;
  logic [N-1:0]   it_out;
  logic           it_v;

  assign acc_nx = mb_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mb_nx  = mb_q >> 1;
  assign prem   = {rem_q, quo_q[N-1]};
  assign trial  = prem - {2'b00, b_q};
  assign div_ge = ~trial[N+1];
  assign rem_nx = div_ge ? trial[N:0] : prem[N:0];
  assign quo_nx = {quo_q[N-2:0], div_ge};

`ifdef ITER_ALU_EARLY_EXIT_EN
  assign mul_early = (op_q == OP_MUL) & (mb_nx == '0);
`else
  assign mul_early = 1'b0;
`endif
  assign step_last = (cnt_q == CW'(N-1)) | mul_early;

  assign it_out = (op_q == OP_MUL)  ? acc_nx[N-1:0] :
                  (op_q == OP_UDIV) ? quo_nx : rem_nx[N-1:0];
  assign it_v   = (op_q == OP_MUL) ? (|acc_nx[2*N-1:N]) : (b_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = is_iter ? EXEC : DONE;
      EXEC: if (step_last) state_d = DONE;
      DONE: begin
        if (accept)         state_d = is_iter ? EXEC : DONE;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mb_q     <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      status_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= EXE_CMD;
        b_q     <= b;
        mcand_q <= {{N{1'b0}}, a};
        acc_q   <= '0;
        mb_q    <= b;
        quo_q   <= a;
        rem_q   <= '0;
        cnt_q   <= '0;
        if (!is_iter) begin
          out_q    <= sc_out;
          status_q <= sc_status;
        end
      end else if (state_q == EXEC) begin
        mcand_q <= mcand_q << 1;
        acc_q   <= acc_nx;
        mb_q    <= mb_nx;
        quo_q   <= quo_nx;
        rem_q   <= rem_nx;
        cnt_q   <= cnt_q + CW'(1);
        if (step_last) begin
          out_q    <= it_out;
          status_q <= {it_out[N-1], ~|it_out, 1'b0, it_v};
        end
      end
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu: scoreboard queue of expected results, immediate-assertion checks.
module tb_iter_alu;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, carryIn, out_valid, out_ready;
  logic [3:0]   EXE_CMD, status;
  logic [N-1:0] a, b, out;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [N-1:0] out;
    logic [3:0]   st;
    logic [7:0]   lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  iter_alu #(.N(N), .CW(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .EXE_CMD(EXE_CMD), .a(a), .b(b), .carryIn(carryIn),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .status(status)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: returns {n,z,c,v, result} computed with wide arithmetic.
  function automatic logic [N+3:0] model(input logic [3:0] op, input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic ci);
    logic [N:0]     s;
    logic [2*N-1:0] p;
    logic [N-1:0]   r, t;
    logic           c, v;
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'h1: r = y;
      4'h9: r = ~y;
      4'h2, 4'h3: begin
        s = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, (op == 4'h3) && ci};
        r = s[N-1:0]; c = s[N];
        v = (x[N-1] == y[N-1]) && (r[N-1] != x[N-1]);
      end
      4'h4, 4'h5: begin
        s = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, (op == 4'h5) && !ci};
        r = s[N-1:0]; c = s[N];
        v = (x[N-1] != y[N-1]) && (r[N-1] != x[N-1]);
      end
      4'h6: r = x & y;
      4'h7: r = x | y;
      4'h8: r = x ^ y;
      4'hA: begin t = x - y; r = t[N-1] ? y : x; end
      4'hB: begin t = y - x; r = t[N-1] ? y : x; end
      4'hC: begin
        p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
        r = p[N-1:0]; v = |p[2*N-1:N];
      end
      4'hD: begin r = (y == 0) ? '1 : x / y; v = (y == 0); end
      4'hE: begin r = (y == 0) ? x : x % y; v = (y == 0); end
      default: r = '0;
    endcase
    return {r[N-1], r == '0, c, v, r};
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [N-1:0] y);
    int steps;
    if (op == 4'hD || op == 4'hE) return N + 1;
    if (op != 4'hC) return 1;
`ifdef ITER_ALU_EARLY_EXIT_EN
    steps = 1;
    for (int i = 0; i < N; i++) if (y[i]) steps = i + 1;
`else
    steps = N;
`endif
    return steps + 1;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [N-1:0] x, input logic [N-1:0] y, input logic ci,
                       input logic [N-1:0] eo, input logic [3:0] es, input int el, input string tag);
    exp_t e;
    EXE_CMD = op; a = x; b = y; carryIn = ci; in_valid = 1'b1;
    #1;
    chk({tag, " in_ready at issue"}, in_ready, 1);
    e.out = eo; e.st = es; e.lat = 8'(el);
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; carryIn = 1'($urandom); EXE_CMD = 4'($urandom);
  endtask

  task automatic collect(input string tag);
    int   lat;
    logic rdy_seen;
    exp_t e;
    lat = 1; rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      tick();
      lat++;
    end
    chk({tag, " in_ready while busy"}, rdy_seen, 0);
    chk({tag, " scoreboard nonempty"}, sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, " latency"}, lat, e.lat);
      chk({tag, " out"}, out, e.out);
      chk({tag, " status"}, status, e.st);
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " out_valid after handshake"}, out_valid, 0);
  endtask

  task automatic run(input logic [3:0] op, input logic [N-1:0] x, input logic [N-1:0] y, input logic ci,
                     input logic [N-1:0] eo, input logic [3:0] es, input int el, input string tag);
    issue(op, x, y, ci, eo, es, el, tag);
    collect(tag);
    release_out(tag);
  endtask

  initial begin
    logic [3:0]   ops[12];
    logic [N+3:0] m;
    logic [N-1:0] x, y;
    logic         ci, seen;

    ops = '{4'h1, 4'h9, 4'h3, 4'h5, 4'h6, 4'hA, 4'hB, 4'hF, 4'h0, 4'hC, 4'hD, 4'hE};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; carryIn = 1'b0; EXE_CMD = '0;
    repeat (3) tick();
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset out", out, 0);
    chk("reset status", status, 0);
    rst = 1'b0;
    tick();

    run(4'h2, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 4'b1001, 1, "add_ovf");
    run(4'h4, 32'd5, 32'd5, 1'b0, 32'h0, 4'b0100, 1, "sub_zero");
    run(4'h5, 32'd5, 32'd5, 1'b0, 32'hFFFF_FFFF, 4'b1010, 1, "sbc_borrow");
`ifdef ITER_ALU_EARLY_EXIT_EN
    run(4'hC, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0, 4'b0101, 18, "mul_ovf");
`else
    run(4'hC, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0, 4'b0101, 33, "mul_ovf");
`endif
    run(4'hD, 32'd100, 32'd7, 1'b0, 32'd14, 4'b0000, 33, "udiv");
    run(4'hE, 32'd100, 32'd7, 1'b0, 32'd2, 4'b0000, 33, "urem");
    run(4'hD, 32'd9, 32'd0, 1'b0, 32'hFFFF_FFFF, 4'b1001, 33, "udiv_by0");
    run(4'hE, 32'd9, 32'd0, 1'b0, 32'd9, 4'b0001, 33, "urem_by0");

    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < 2; r++) begin
        x = $urandom; y = $urandom; ci = 1'($urandom);
        if (r == 1) y = y >> 20;
        m = model(ops[i], x, y, ci);
        run(ops[i], x, y, ci, m[N-1:0], m[N+3:N], exp_lat(ops[i], y), $sformatf("op%0h_%0d", ops[i], r));
      end
    end

    // Backpressure: hold the ORR result, then hand off straight into an EOR.
    issue(4'h7, 32'hF0F0_0000, 32'h0000_0F0F, 1'b0, 32'hF0F0_0F0F, 4'b1000, 1, "orr");
    collect("orr");
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("orr held out", out, 32'hF0F0_0F0F);
      chk("orr held status", status, 4'b1000);
      chk("orr held out_valid", out_valid, 1);
      chk("orr held in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    issue(4'h8, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b0, 32'hF00F_F00F, 4'b1000, 1, "eor_b2b");
    out_ready = 1'b0;
    collect("eor_b2b");
    release_out("eor_b2b");

    // Reset in the 10th cycle of a multiply must drop it without a result.
    EXE_CMD = 4'hC; a = 32'h0000_FFFF; b = 32'h0000_FFFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mul_rst out_valid", out_valid, 0);
    chk("mul_rst out", out, 0);
    chk("mul_rst status", status, 0);
    chk("mul_rst in_ready", in_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("mul_rst no stale result", seen, 0);
    run(4'h2, 32'd2, 32'd3, 1'b0, 32'd5, 4'b0000, 1, "add_after_rst");

    chk("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised, multi-cycle successor to the processor's combinational ALU.
- Keeps the single-cycle operations: MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR, SORT1, SORT2.
- Adds iterative unsigned MUL, UDIV and UREM.
- Sits in the EXE stage behind a valid/ready handshake, so the pipeline can stall on long operations.

Parameters:
- N, 32, operand/result width (N >= 4).
- CW, 6, iteration counter width; must satisfy 2^CW > N.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request this cycle.
- EXE_CMD  input  4  operation code.
- a  input  N  operand A.
- b  input  N  operand B.
- carryIn  input  1  C flag for ADC/SBC.
- out_valid  output  1  result and status are valid.
- out_ready  input  1  consumer accepts the result.
- out  output  N  result.
- status  output  4  {n,z,c,v}.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, out=0, status=0, counter=0. Reset mid-operation abandons the operation; no result is produced.
- Accept: in_valid & in_ready. a, b, carryIn and EXE_CMD are captured; later input changes are ignored.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Back-to-back accept in the same cycle as the output handshake is legal.
- States:
  - IDLE: on accept of a single-cycle op -> DONE; on accept of MUL/UDIV/UREM -> EXEC with counter=0.
  - EXEC: one shift-add or restoring-divide step per cycle. After step N-1 -> DONE.
  - DONE: out_valid=1; out/status held stable. If out_ready: -> IDLE, or straight to the next op's state if a request is accepted the same cycle.
- Latency: single-cycle op, out_valid in the cycle after accept. MUL/UDIV/UREM, out_valid N+1 cycles after accept.
- Opcodes and results:
  - 0001 MOV: out=b.
  - 1001 MVN: out=~b.
  - 0010 ADD: {c,out}=a+b.
  - 0011 ADC: {c,out}=a+b+carryIn.
  - 0100 SUB: {c,out}=a-b (N+1-bit, c is borrow).
  - 0101 SBC: {c,out}=a-b-~carryIn.
  - 0110 AND, 0111 ORR, 1000 EOR.
  - 1010 SORT1: out = (a-b)[N-1] ? b : a.
  - 1011 SORT2: out = (b-a)[N-1] ? b : a.
  - 1100 MUL: out = low N bits of a*b (unsigned).
  - 1101 UDIV: out = a/b.
  - 1110 UREM: out = a%b.
  - Others (0000, 1111): out=0, status=0100, latency 1.
- Flags: n=out[N-1]; z=(out==0).
  - c: carry/borrow for ADD/ADC/SUB/SBC; 0 otherwise.
  - v, ADD/ADC: a[N-1]==b[N-1] & out[N-1]!=a[N-1].
  - v, SUB/SBC: a[N-1]!=b[N-1] & out[N-1]!=a[N-1].
  - v, MUL: 1 if the upper N bits of the 2N-bit product are non-zero.
  - v, UDIV/UREM: 1 if b==0.
  - v: 0 for all other ops.
- Divide by zero: runs the full N steps. UDIV out = all ones; UREM out = a; v=1.
- Internal datapath: MUL uses a 2N-bit accumulator. Divide uses an (N+1)-bit partial remainder.
- out_valid deasserts only via the handshake or reset.

Optional Feature:
- Macro ITER_ALU_EARLY_EXIT_EN.
- Defined: MUL leaves EXEC as soon as the remaining unshifted multiplier bits are all zero, evaluated after each step (minimum 1 EXEC cycle). Latency for MUL is therefore 2..N+1 cycles; results and flags are identical to the full run. UDIV/UREM are unaffected.
- Undefined: MUL always takes N EXEC cycles.

Test Plan:
- ADD a=0x7FFFFFFF b=0x00000001 -> out=0x80000000, status=4'b1001, out_valid 1 cycle after accept.
- SUB a=5 b=5 -> out=0, status=4'b0100. SBC a=5 b=5 carryIn=0 -> out=0xFFFFFFFF, c=1, status=4'b1010.
- MUL a=0x00010000 b=0x00010000 -> out=0, status=4'b0101, out_valid exactly 33 cycles after accept (macro off); in_ready=0 throughout EXEC.
- UDIV 100/7 -> out=14; UREM 100/7 -> out=2. UDIV 9/0 -> out=0xFFFFFFFF, status=4'b1001; UREM 9/0 -> out=9, v=1.
- Backpressure: hold out_ready=0 for 5 cycles after an ORR result; out/status stay stable and in_ready=0. Then out_ready=1 with in_valid=1 (EOR) in the same cycle; EOR is accepted and its result is valid next cycle.
- Assert rst during cycle 10 of a MUL -> next cycle state=IDLE, out_valid=0, out=0, in_ready=1. No stale result appears; a following ADD 2+3 -> out=5.
